// File: rtl/baud_gen_frac.sv
// Fractional baud/sample tick generator with shift-add period multiplier and boundary-aligned config switch.
// Optional build macro BAUD_GEN_RESYNC_EN adds the resync input for mid-bit phase realignment.
module baud_gen_frac #(
  parameter int unsigned DL_WIDTH   = 16,
  parameter int unsigned PSD_WIDTH  = 4,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OSR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_load,
  input  logic [DL_WIDTH-1:0]   dl,
  input  logic [PSD_WIDTH-1:0]  psd,
  input  logic [FRAC_WIDTH-1:0] frac,
  input  logic [OSR_WIDTH-1:0]  osr,
`ifdef BAUD_GEN_RESYNC_EN
  input  logic                  resync,
`endif
  output logic                  cfg_busy,
  output logic                  sample_tick,
  output logic                  baud_tick,
  output logic                  active
);

  localparam int unsigned P_W  = DL_WIDTH + PSD_WIDTH + 1;
  localparam int unsigned M_W  = PSD_WIDTH + 1;
  localparam int unsigned MC_W = $clog2(M_W + 1);
  localparam logic [MC_W-1:0] MUL_DONE = MC_W'(M_W);

  typedef enum logic [1:0] {IDLE, CALC, WAIT_BND, RUN} state_t;

  state_t                state_q, state_d;
  logic [P_W-1:0]        mcand_q, prod_q, p_act_q, scnt_q;
  logic [M_W-1:0]        mplier_q;
  logic [MC_W-1:0]       mul_cnt_q;
  logic [FRAC_WIDTH-1:0] frac_sh_q, frac_act_q, acc_q, acc_sum;
  logic [OSR_WIDTH-1:0]  osr_sh_q, osr_act_q, sidx_q;
  logic                  have_cfg_q, acc_carry;
  logic                  apply, mul_done, run, tick, resync_c;
  logic [P_W-1:0]        dl_eff;
  logic [OSR_WIDTH-1:0]  osr_clamp;

  assign dl_eff    = (dl == '0) ? (P_W'(1) << DL_WIDTH) : P_W'(dl);
  // osr_clamp holds samples-per-bit minus one, so it doubles as the last sample index
  assign osr_clamp = (osr < OSR_WIDTH'(3)) ? OSR_WIDTH'(3) : osr;
  assign mul_done  = (mul_cnt_q == MUL_DONE);
  assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_act_q};

  assign run = have_cfg_q && enable;

`ifdef BAUD_GEN_RESYNC_EN
  assign resync_c = resync && run && (state_q == RUN) && !apply;
`else
  assign resync_c = 1'b0;
`endif

  assign tick        = run && (scnt_q == '0) && !resync_c;
  assign sample_tick = tick;
  assign baud_tick   = tick && (sidx_q == osr_act_q);
  assign active      = run;
  assign cfg_busy    = (state_q == CALC) || (state_q == WAIT_BND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    if (cfg_load) begin
      state_d = CALC;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        CALC: begin
          if (mul_done) begin
            if (!have_cfg_q || !enable) begin
              apply   = 1'b1;
              state_d = RUN;
            end else begin
              state_d = WAIT_BND;
            end
          end
        end
        WAIT_BND: begin
          if (!enable || baud_tick) begin
            apply   = 1'b1;
            state_d = RUN;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      mul_cnt_q  <= '0;
      frac_sh_q  <= '0;
      osr_sh_q   <= '0;
      p_act_q    <= '0;
      frac_act_q <= '0;
      osr_act_q  <= '0;
      have_cfg_q <= 1'b0;
      scnt_q     <= '0;
      acc_q      <= '0;
      sidx_q     <= '0;
    end else begin
      if (cfg_load) begin
        mcand_q   <= dl_eff;
        mplier_q  <= M_W'(psd) + M_W'(1);
        prod_q    <= '0;
        mul_cnt_q <= '0;
        frac_sh_q <= frac;
        osr_sh_q  <= osr_clamp;
      end else if (state_q == CALC && !mul_done) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q   <= mcand_q << 1;
        mplier_q  <= mplier_q >> 1;
        mul_cnt_q <= mul_cnt_q + 1'b1;
      end

      // Apply overrides the tick update so the old config's final baud tick hands over cleanly
      if (apply) begin
        p_act_q    <= prod_q;
        frac_act_q <= frac_sh_q;
        osr_act_q  <= osr_sh_q;
        have_cfg_q <= 1'b1;
        scnt_q     <= prod_q - 1'b1;
        acc_q      <= '0;
        sidx_q     <= '0;
      end else if (resync_c) begin
        scnt_q <= p_act_q >> 1;
        acc_q  <= '0;
        sidx_q <= '0;
      end else if (!run) begin
        // Held at P so the first tick lands P clocks after enable rises
        scnt_q <= p_act_q;
        acc_q  <= '0;
        sidx_q <= '0;
      end else if (scnt_q == '0) begin
        acc_q  <= acc_sum;
        scnt_q <= acc_carry ? p_act_q : p_act_q - 1'b1;
        sidx_q <= (sidx_q == osr_act_q) ? '0 : sidx_q + 1'b1;
      end else begin
        scnt_q <= scnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: table of rate configs plus hand sequences for live change, reset and enable.
module tb_baud_gen_frac;

  localparam int PSD_W = 4;

  logic        clk = 1'b0;
  logic        reset, enable, cfg_load;
  logic [15:0] dl;
  logic [3:0]  psd, frac;
  logic [4:0]  osr;
  logic        cfg_busy, sample_tick, baud_tick, active;
`ifdef BAUD_GEN_RESYNC_EN
  logic        resync = 1'b0;
`endif

  baud_gen_frac #(.DL_WIDTH(16), .PSD_WIDTH(4), .FRAC_WIDTH(4), .OSR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .dl(dl), .psd(psd), .frac(frac), .osr(osr),
`ifdef BAUD_GEN_RESYNC_EN
    .resync(resync),
`endif
    .cfg_busy(cfg_busy), .sample_tick(sample_tick), .baud_tick(baud_tick), .active(active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (baud_tick) chk("baud_with_sample", sample_tick, 1);

  int st_c[8];
  int bt_c[4];
  int st_n, bt_n, busy_n, busy_last;

  // Examines the current cycle first, then advances; returns on the cycle that satisfied the request
  task automatic collect(input int want_st, input int want_bt, input int budget);
    st_n = 0; bt_n = 0; busy_n = 0; busy_last = -1;
    for (int i = 0; i < budget; i++) begin
      if (cfg_busy) begin busy_n++; busy_last = cyc; end
      if (sample_tick && st_n < 8) begin st_c[st_n] = cyc; st_n++; end
      if (baud_tick && bt_n < 4) begin bt_c[bt_n] = cyc; bt_n++; end
      if (st_n >= want_st && bt_n >= want_bt) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cfg_load = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] f, input logic [4:0] o);
    dl = d; psd = p; frac = f; osr = o; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] dl;
    logic [3:0]  psd;
    logic [3:0]  frac;
    logic [4:0]  osr;
    int          first;
    int          sp0;
    int          sp1;
    int          baud;
  } vec_t;

  vec_t vt[6];
  int   c0, b0, e0, bad;
  int   exp_st[6];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    dl = '0; psd = '0; frac = '0; osr = '0;
    #1;
    chk("reset_outputs", {cfg_busy, sample_tick, baud_tick, active}, 0);

    // first = cycles from cfg_load to first tick = PSD_W+2+P
    vt[0] = '{16'd1, 4'd0,  4'd0, 5'd15, 7,  1, 1, 16};
    vt[1] = '{16'd2, 4'd15, 4'd0, 5'd3,  38, 32, 32, 128};
    vt[2] = '{16'd4, 4'd0,  4'd8, 5'd3,  10, 4, 5, 18};
    vt[3] = '{16'd1, 4'd0,  4'd0, 5'd1,  7,  1, 1, 4};
    vt[4] = '{16'd2, 4'd0,  4'd0, 5'd12, 8,  2, 2, 26};
    vt[5] = '{16'd3, 4'd2,  4'd4, 5'd0,  15, 9, 9, 37};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      c0 = cyc;
      load(vt[v].dl, vt[v].psd, vt[v].frac, vt[v].osr);
      collect(4, 3, 3000);
      chk($sformatf("vec%0d_events_seen", v), (st_n >= 4 && bt_n >= 3), 1);
      chk($sformatf("vec%0d_busy_cycles", v), busy_n, PSD_W + 2);
      chk($sformatf("vec%0d_first_tick", v), st_c[0] - c0, vt[v].first);
      chk($sformatf("vec%0d_sample_period0", v), st_c[1] - st_c[0], vt[v].sp0);
      chk($sformatf("vec%0d_sample_period1", v), st_c[2] - st_c[1], vt[v].sp1);
      chk($sformatf("vec%0d_baud_period", v), bt_c[2] - bt_c[1], vt[v].baud);
    end
    chk("active_in_run", active, 1);

    // Zero divisor means 2^16
    do_reset();
    c0 = cyc;
    load(16'd0, 4'd0, 4'd0, 5'd15);
    collect(1, 0, 70000);
    chk("zero_dl_seen", st_n, 1);
    chk("zero_dl_first_tick", st_c[0] - c0, PSD_W + 2 + 65536);

    // Live change mid-bit with a second load during CALC
    do_reset();
    load(16'd10, 4'd0, 4'd0, 5'd3);
    collect(0, 1, 200);
    chk("live_first_baud_seen", bt_n, 1);
    b0 = bt_c[0];
    repeat (3) @(negedge clk);
    load(16'd7, 4'd0, 4'd0, 5'd3);
    @(negedge clk);
    load(16'd3, 4'd0, 4'd0, 5'd3);
    collect(6, 2, 200);
    chk("live_events_seen", (st_n >= 6 && bt_n >= 2), 1);
    exp_st = '{10, 20, 30, 40, 43, 46};
    for (int i = 0; i < 6; i++) chk($sformatf("live_tick%0d", i), st_c[i] - b0, exp_st[i]);
    chk("live_switch_baud", bt_c[0] - b0, 40);
    chk("live_next_baud", bt_c[1] - b0, 52);
    chk("live_busy_last", busy_last - b0, 40);

    // Reset while a config waits for the baud boundary
    do_reset();
    load(16'd10, 4'd0, 4'd0, 5'd3);
    collect(0, 1, 200);
    b0 = bt_c[0];
    @(negedge clk);
    load(16'd3, 4'd0, 4'd0, 5'd3);
    repeat (18) @(negedge clk);
    chk("waitbnd_busy", cfg_busy, 1);
    chk("waitbnd_old_tick", sample_tick, 1);
    reset = 1'b1;
    #1;
    chk("waitbnd_reset_async", {cfg_busy, sample_tick, baud_tick, active}, 0);
    repeat (2) @(negedge clk);
    chk("waitbnd_reset_held", {cfg_busy, sample_tick, baud_tick, active}, 0);
    reset = 1'b0;

    // Enable low for 50 cycles, then first tick P=5 clocks after re-enable
    do_reset();
    load(16'd5, 4'd0, 4'd0, 5'd3);
    collect(2, 0, 200);
    chk("enable_pre_ticks", st_n, 2);
    @(negedge clk);
    enable = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (sample_tick || baud_tick || active) bad++;
    end
    chk("disabled_quiet", bad, 0);
    enable = 1'b1;
    e0 = cyc;
    #1;
    chk("reenable_active", active, 1);
    collect(1, 0, 100);
    chk("reenable_first_tick", st_c[0] - e0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the UART baud generator. Adds a fractional divisor, a programmable oversampling ratio, a load/busy handshake, and glitch-free divisor changes at baud boundaries.
- Produces sample_tick (oversampled rate) and baud_tick (bit rate) for the UART TX/RX engines.
- Sits between the register file (DLL/DLM/PSD/DLF/OSR registers) and the serialiser/deserialiser.

Parameters:
- DL_WIDTH, 16, divisor latch width (DLM:DLL).
- PSD_WIDTH, 4, prescaler field width; divide by psd+1.
- FRAC_WIDTH, 4, fractional divisor width; fraction = frac/2^FRAC_WIDTH.
- OSR_WIDTH, 5, oversampling field width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  generator enable; low holds the generator stopped
- cfg_load  in  1  single-cycle pulse; captures dl/psd/frac/osr
- dl  in  DL_WIDTH  divisor latch; 0 means 2^DL_WIDTH
- psd  in  PSD_WIDTH  prescaler; effective divide is psd+1
- frac  in  FRAC_WIDTH  fractional part of the sample period
- osr  in  OSR_WIDTH  samples per bit minus 1; values below 3 clamp to 4 samples
- cfg_busy  out  1  high while a captured config is not yet in effect
- sample_tick  out  1  one-cycle pulse per sample period
- baud_tick  out  1  one-cycle pulse per bit; always coincides with a sample_tick
- active  out  1  high while a valid config is running and enable=1

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; counters, fractional accumulator and shadow registers 0.
- Arithmetic:
  - dl_eff = (dl==0) ? 2^DL_WIDTH : dl.
  - P = dl_eff*(psd+1), width DL_WIDTH+PSD_WIDTH+1.
  - osr_eff = (osr<3) ? 4 : osr+1.
- Multiplier: iterative shift-add over PSD_WIDTH+1 cycles. Internal; no DSP inference required.
- Fractional accumulation: acc (FRAC_WIDTH bits) adds frac at every sample_tick.
  - A carry-out makes the next sample period P+1 clocks; otherwise the period is P clocks.
  - acc wraps modulo 2^FRAC_WIDTH.
- Tick timing:
  - sample_tick asserts on the clock where the sample counter reaches 0; the counter reloads in the same cycle.
  - baud_tick asserts on the osr_eff-th sample_tick of each bit, in the same cycle as that sample_tick.
- FSM states: IDLE, CALC, WAIT_BND, RUN.
  - IDLE: no valid config. Ticks 0, active 0. cfg_load -> CALC.
  - CALC: multiply; cfg_busy=1. After PSD_WIDTH+1 cycles: if no config has ever been applied, or enable=0, apply immediately -> RUN. Otherwise -> WAIT_BND.
  - WAIT_BND: old config keeps running; cfg_busy=1. The new config is applied in the cycle of the next baud_tick (counters, acc and sample index reload) -> RUN.
  - RUN: cfg_busy=0. Ticks generated while enable=1. cfg_load -> CALC, and the old config keeps ticking during CALC.
- Applying a config: cfg_busy falls the cycle after apply. The first sample_tick comes P clocks after the apply cycle.
- Latency: first-ever load, cfg_load at cycle 0 -> cfg_busy=1 at cycle 1 -> applied at cycle PSD_WIDTH+2 -> cfg_busy=0 at cycle PSD_WIDTH+3.
- cfg_load while cfg_busy=1: new values are recaptured and CALC restarts. Last write wins; the previous pending config is discarded.
- enable=0:
  - Counters, acc and sample index are held at their reload values. Ticks 0, active 0.
  - A pending WAIT_BND config is applied immediately.
  - enable 0->1: the first sample_tick comes P clocks later.
- cfg_load in the same cycle as a baud_tick in WAIT_BND: the capture wins, the pending config is discarded, and the FSM goes -> CALC.
- Reset mid-operation (any state): everything returns to the reset values. No tick is emitted in the reset cycle.

Optional Feature:
- Macro: BAUD_GEN_RESYNC_EN.
- Defined: adds input port resync (1 bit). A pulse while in RUN reloads the sample counter to P/2, zeroes acc, and zeroes the sample index. This lets RX realign to a detected start-bit edge mid-bit.
  - No tick is emitted in the resync cycle.
  - resync coincident with an apply: the apply takes priority.
- Undefined: no resync port; phase changes only via apply, enable or reset.

Test Plan:
- Fastest rate: dl=1, psd=0, frac=0, osr=15, enable=1, one cfg_load -> sample_tick every clock; baud_tick every 16 clocks; cfg_busy high for exactly PSD_WIDTH+2 cycles.
- Zero divisor: dl=0, psd=0, osr=15 -> sample period 65536 clocks; baud period 1048576 clocks. psd=15 with dl=2 -> sample period 32.
- Fractional: dl=4, psd=0, frac=8 (FRAC_WIDTH=4), osr=3 -> sample periods alternate 4,5,4,5; each baud period is 18 clocks.
- OSR clamp: osr=1 -> 4 samples per baud; osr=12 -> 13 samples per baud.
- Live change: RUN with dl=10; cfg_load dl=3 mid-bit -> old 10-clock period continues until baud_tick, then 3-clock periods with no runt tick. Second cfg_load during CALC -> only the last config is applied.
- Reset and enable: assert reset during WAIT_BND -> all outputs 0 immediately. enable low for 50 cycles in RUN -> no ticks; first sample_tick P clocks after re-enable.
